// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    // Addresses below the reset vector are reserved for indirect addressing.
    localparam logic [15:0] RESET_VEC = 16'h0010;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Clear/enable cycle counter; expired_o flags the LIMIT-th enabled cycle since clear.
module fetch_timer #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_limit;

    assign at_limit  = (cnt_q == W'(LIMIT - 1));
    assign expired_o = en_i && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads one instruction per FETCH_START and returns PC+1 to the PC.
// Define FETCH_TIMEOUT_EN to abort a stalled read after TIMEOUT cycles with a NOP.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W    = ADDR_W_DEF,
    parameter int unsigned          DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]    RESET_VEC = fetch_pkg::RESET_VEC
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned          TIMEOUT   = 8
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH_START,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR,
    input  logic [ADDR_W-1:0] PC_OUT,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_RDY,
    output logic [DATA_W-1:0] IR_OUT,
    output logic              IR_VALID,
    output logic [ADDR_W-1:0] PC_IN,
    output logic              PC_en,
    output logic              BUSY,
    output logic              FETCH_ERR
);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0] pc_in_q, pc_in_d;
    logic              pc_en_q, pc_en_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
    logic timer_clr, timer_en, timer_expired;

    fetch_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        pc_in_d    = pc_in_q;
        pc_en_d    = 1'b0;
        err_d      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // A simultaneous fetch request is dropped in favour of the redirect.
                if (REDIRECT) begin
                    pc_in_d = REDIRECT_ADDR;
                    pc_en_d = 1'b1;
                end else if (FETCH_START) begin
                    mem_addr_d = PC_OUT;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
`ifdef FETCH_TIMEOUT_EN
                    timer_clr  = 1'b1;
`endif
                end
            end
            REQ: begin
`ifdef FETCH_TIMEOUT_EN
                timer_en = 1'b1;
`endif
                if (MEM_RDY) begin
                    mem_req_d  = 1'b0;
                    ir_d       = MEM_RDATA;
                    ir_valid_d = 1'b1;
                    pc_in_d    = mem_addr_q + 1'b1;
                    pc_en_d    = 1'b1;
                    state_d    = DONE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timer_expired) begin
                    mem_req_d  = 1'b0;
                    ir_d       = DATA_W'(NOP_INSTR);
                    ir_valid_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VEC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_in_q    <= RESET_VEC;
            pc_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_in_q    <= pc_in_d;
            pc_en_q    <= pc_en_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign MEM_REQ   = mem_req_q;
    assign MEM_ADDR  = mem_addr_q;
    assign IR_OUT    = ir_q;
    assign IR_VALID  = ir_valid_q;
    assign PC_IN     = pc_in_q;
    assign PC_en     = pc_en_q;
    assign BUSY      = busy_q;
    assign FETCH_ERR = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_instr_fetch;

    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        RST, FETCH_START, REDIRECT, MEM_RDY;
    logic [15:0] REDIRECT_ADDR, PC_OUT, MEM_RDATA;
    logic        MEM_REQ, IR_VALID, PC_en, BUSY, FETCH_ERR;
    logic [15:0] MEM_ADDR, IR_OUT, PC_IN;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    instr_fetch dut (
        .CLK          (CLK),
        .RST          (RST),
        .FETCH_START  (FETCH_START),
        .REDIRECT     (REDIRECT),
        .REDIRECT_ADDR(REDIRECT_ADDR),
        .PC_OUT       (PC_OUT),
        .MEM_REQ      (MEM_REQ),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RDATA    (MEM_RDATA),
        .MEM_RDY      (MEM_RDY),
        .IR_OUT       (IR_OUT),
        .IR_VALID     (IR_VALID),
        .PC_IN        (PC_IN),
        .PC_en        (PC_en),
        .BUSY         (BUSY),
        .FETCH_ERR    (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: tracks the outstanding transaction, not the RTL's registers.
    bit          m_valid = 0;
    bit          m_busy_txn;     // a read is outstanding
    bit          m_retire;       // transaction retired last edge, one bubble cycle follows
    int          m_wait;         // cycles spent waiting on the memory
    logic [15:0] m_addr, m_ir, m_pcin;
    bit          m_irv, m_pcen, m_err;

    always @(posedge CLK) begin
        if (RST) begin
            m_valid = 1; m_busy_txn = 0; m_retire = 0; m_wait = 0;
            m_addr = 16'h0010; m_pcin = 16'h0010; m_ir = 16'h0000;
            m_irv = 0; m_pcen = 0; m_err = 0;
        end else if (m_valid) begin
            m_irv = 0; m_pcen = 0; m_err = 0;
            if (m_retire) begin
                m_retire = 0;
            end else if (m_busy_txn) begin
                m_wait++;
                if (MEM_RDY) begin
                    m_ir = MEM_RDATA; m_irv = 1;
                    m_pcin = 16'(int'(m_addr) + 1); m_pcen = 1;
                    m_busy_txn = 0; m_retire = 1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (m_wait == TO) begin
                    m_ir = 16'h0000; m_irv = 1; m_err = 1;
                    m_busy_txn = 0; m_retire = 1;
                end
`endif
            end else if (REDIRECT) begin
                m_pcin = REDIRECT_ADDR; m_pcen = 1;
            end else if (FETCH_START) begin
                m_addr = PC_OUT; m_busy_txn = 1; m_wait = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("mdl MEM_REQ",   32'(MEM_REQ),   32'(m_busy_txn));
            chk("mdl MEM_ADDR",  32'(MEM_ADDR),  32'(m_addr));
            chk("mdl IR_OUT",    32'(IR_OUT),    32'(m_ir));
            chk("mdl IR_VALID",  32'(IR_VALID),  32'(m_irv));
            chk("mdl PC_IN",     32'(PC_IN),     32'(m_pcin));
            chk("mdl PC_en",     32'(PC_en),     32'(m_pcen));
            chk("mdl BUSY",      32'(BUSY),      32'(m_busy_txn || m_retire));
            chk("mdl FETCH_ERR", 32'(FETCH_ERR), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1; FETCH_START = 0; REDIRECT = 0; MEM_RDY = 0;
        REDIRECT_ADDR = '0; PC_OUT = '0; MEM_RDATA = '0;
        step(); step();
        chk("rst MEM_ADDR", 32'(MEM_ADDR), 32'h0010);
        chk("rst PC_IN",    32'(PC_IN),    32'h0010);
        chk("rst MEM_REQ",  32'(MEM_REQ),  32'h0);
        chk("rst IR_OUT",   32'(IR_OUT),   32'h0);
        chk("rst BUSY",     32'(BUSY),     32'h0);
        RST = 0;

        // 1: three stall cycles then data
        PC_OUT = 16'h0010; FETCH_START = 1; step(); FETCH_START = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin MEM_RDY = 1; MEM_RDATA = 16'hA5C3; end
            chk("t1 MEM_REQ held",  32'(MEM_REQ),  32'h1);
            chk("t1 MEM_ADDR held", 32'(MEM_ADDR), 32'h0010);
            step();
        end
        MEM_RDY = 0;
        chk("t1 IR_OUT",   32'(IR_OUT),   32'hA5C3);
        chk("t1 IR_VALID", 32'(IR_VALID), 32'h1);
        chk("t1 PC_en",    32'(PC_en),    32'h1);
        chk("t1 PC_IN",    32'(PC_IN),    32'h0011);
        chk("t1 MEM_REQ",  32'(MEM_REQ),  32'h0);
        step();
        chk("t1 IR_VALID end", 32'(IR_VALID), 32'h0);
        chk("t1 BUSY end",     32'(BUSY),     32'h0);

        // 2: redirect while idle
        REDIRECT = 1; REDIRECT_ADDR = 16'h0040; step(); REDIRECT = 0;
        chk("t2 PC_en",   32'(PC_en),   32'h1);
        chk("t2 PC_IN",   32'(PC_IN),   32'h0040);
        chk("t2 MEM_REQ", 32'(MEM_REQ), 32'h0);
        step();
        chk("t2 PC_en end", 32'(PC_en), 32'h0);

        // 3: redirect beats a same-cycle fetch
        REDIRECT = 1; REDIRECT_ADDR = 16'h0080; FETCH_START = 1; PC_OUT = 16'h0123;
        step(); REDIRECT = 0; FETCH_START = 0;
        chk("t3 PC_IN",   32'(PC_IN),   32'h0080);
        chk("t3 PC_en",   32'(PC_en),   32'h1);
        chk("t3 MEM_REQ", 32'(MEM_REQ), 32'h0);
        step();
        chk("t3 MEM_REQ later", 32'(MEM_REQ), 32'h0);

        // 4: PC wraps at the top of the address space
        PC_OUT = 16'hFFFF; FETCH_START = 1; step(); FETCH_START = 0;
        MEM_RDY = 1; MEM_RDATA = 16'h1234; step(); MEM_RDY = 0;
        chk("t4 PC_IN",    32'(PC_IN),    32'h0000);
        chk("t4 IR_VALID", 32'(IR_VALID), 32'h1);
        step();
        chk("t4 IR_VALID one cycle", 32'(IR_VALID), 32'h0);

        // 5: reset during REQ, late MEM_RDY ignored
        PC_OUT = 16'h0020; FETCH_START = 1; step(); FETCH_START = 0;
        RST = 1; step(); RST = 0;
        chk("t5 MEM_REQ", 32'(MEM_REQ), 32'h0);
        chk("t5 PC_IN",   32'(PC_IN),   32'h0010);
        chk("t5 PC_en",   32'(PC_en),   32'h0);
        MEM_RDY = 1; MEM_RDATA = 16'hBEEF; step(); MEM_RDY = 0;
        chk("t5 late PC_en",    32'(PC_en),    32'h0);
        chk("t5 late IR_VALID", 32'(IR_VALID), 32'h0);
        chk("t5 late IR_OUT",   32'(IR_OUT),   32'h0000);

`ifdef FETCH_TIMEOUT_EN
        // 6: memory never answers
        PC_OUT = 16'h0030; FETCH_START = 1; step(); FETCH_START = 0;
        for (int i = 0; i < TO - 1; i++) step();
        chk("t6 MEM_REQ before timeout", 32'(MEM_REQ), 32'h1);
        step();
        chk("t6 FETCH_ERR", 32'(FETCH_ERR), 32'h1);
        chk("t6 IR_OUT",    32'(IR_OUT),    32'h0000);
        chk("t6 IR_VALID",  32'(IR_VALID),  32'h1);
        chk("t6 PC_en",     32'(PC_en),     32'h0);
        chk("t6 MEM_REQ",   32'(MEM_REQ),   32'h0);
        step();
        chk("t6 FETCH_ERR pulse", 32'(FETCH_ERR), 32'h0);
`endif

        // Randomized traffic; the controller only requests while not busy.
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            if (!BUSY) begin
                FETCH_START = ($urandom_range(0, 2) == 0);
                REDIRECT    = ($urandom_range(0, 5) == 0);
            end else begin
                FETCH_START = 0;
                REDIRECT    = 0;
            end
            PC_OUT        = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            REDIRECT_ADDR = 16'($urandom);
            MEM_RDY       = ($urandom_range(0, 4) == 0);
            MEM_RDATA     = 16'($urandom);
            step();
        end
        RST = 0; FETCH_START = 0; REDIRECT = 0; MEM_RDY = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
